// File: rtl/subtree_resp_collector.sv
// subtree_resp_collector
// ----------------------
// Merges response beats from NUM_CHILD child subtrees into one upstream
// stream toward the parent. Children are served round-robin. Accepted beats
// are buffered in a small FIFO, and each beat is tagged with the index of
// the child that produced it.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   child_valid  per-child beat valid
//   child_data   per-child payload, child i at [i*DATA_W +: DATA_W]
//   child_ready  one-hot-or-zero accept back to the children
//   up_valid     upstream beat valid (FIFO not empty)
//   up_ready     upstream accept
//   up_data      payload at the FIFO head (0 while empty)
//   up_src       originating child index at the FIFO head (0 while empty)
//   fifo_level   current FIFO occupancy, 0..FIFO_DEPTH
//
// Optional build macro COLLECTOR_STATS_EN adds these ports:
//   beat_count   32-bit wrapping count of upstream pops
//   stall_cycles 16-bit saturating count of cycles with up_valid & !up_ready
module subtree_resp_collector #(
  parameter int NUM_CHILD  = 5,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CHILD-1:0]            child_valid,
  input  logic [NUM_CHILD*DATA_W-1:0]     child_data,
  output logic [NUM_CHILD-1:0]            child_ready,
  output logic                            up_valid,
  input  logic                            up_ready,
  output logic [DATA_W-1:0]               up_data,
  output logic [$clog2(NUM_CHILD)-1:0]    up_src,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
`ifdef COLLECTOR_STATS_EN
  ,
  output logic [31:0]                     beat_count,
  output logic [15:0]                     stall_cycles
`endif
);

  localparam int SRC_W = $clog2(NUM_CHILD);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CND_W = SRC_W + 1;

  localparam logic [SRC_W-1:0] LAST_CHILD = SRC_W'(NUM_CHILD - 1);
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);
  localparam logic [CND_W-1:0] NUM_CND    = CND_W'(NUM_CHILD);

  logic [SRC_W-1:0]  last_grant;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
  logic [SRC_W-1:0]  src_mem  [FIFO_DEPTH];

  logic              fifo_full;
  logic              grant_found;
  logic [SRC_W-1:0]  grant_idx;
  logic [DATA_W-1:0] grant_data;
  logic              push;
  logic              pop;

  assign fifo_full = (fifo_level == FULL_LEVEL);

  // Round-robin scan starting just after the last granted child. The
  // candidate index is kept one bit wider than a child index so that
  // last_grant + k never overflows before the modulo correction.
  always_comb begin
    logic [CND_W-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_CHILD; k++) begin
      cand = {1'b0, last_grant} + CND_W'(k);
      if (cand >= NUM_CND) begin
        cand = cand - NUM_CND;
      end
      if (!grant_found && child_valid[cand[SRC_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[SRC_W-1:0];
      end
    end
  end

  // Payload of the granted child, selected by index.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_CHILD; i++) begin
      if (grant_idx == SRC_W'(i)) begin
        grant_data = child_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // A full FIFO blocks every child even if the head is popping this cycle;
  // the freed slot becomes visible only once the level register updates.
  assign push        = grant_found && !fifo_full;
  assign child_ready = push ? (NUM_CHILD'(1) << grant_idx) : '0;

  assign up_valid = (fifo_level != '0);
  assign pop      = up_valid && up_ready;
  assign up_data  = up_valid ? data_mem[rd_ptr] : '0;
  assign up_src   = up_valid ? src_mem[rd_ptr]  : '0;

  // Storage needs no reset; the level and pointers decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= grant_data;
      src_mem[wr_ptr]  <= grant_idx;
    end
  end

  // Pointers wrap naturally since FIFO_DEPTH is a power of two. The level
  // holds when a push and a pop coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      last_grant <= LAST_CHILD;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + 1'b1;
        last_grant <= grant_idx;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

`ifdef COLLECTOR_STATS_EN
  // The pop count wraps freely; the stall count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_count   <= '0;
      stall_cycles <= '0;
    end else begin
      if (pop) begin
        beat_count <= beat_count + 32'd1;
      end
      if (up_valid && !up_ready && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_subtree_resp_collector.sv
// Testbench for subtree_resp_collector. A queue-based model of the collector
// is compared against the DUT every cycle. Directed scenarios add literal
// expectations that pin the model. It honours COLLECTOR_STATS_EN the same
// way the design does.
module tb_subtree_resp_collector;

  localparam int NC = 5;
  localparam int DW = 16;
  localparam int FD = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NC-1:0]   child_valid = '0;
  logic [NC*DW-1:0] child_data = '0;
  logic [NC-1:0]   child_ready;
  logic            up_valid;
  logic            up_ready = 1'b0;
  logic [DW-1:0]   up_data;
  logic [2:0]      up_src;
  logic [2:0]      fifo_level;
`ifdef COLLECTOR_STATS_EN
  logic [31:0]     beat_count;
  logic [15:0]     stall_cycles;
`endif

  subtree_resp_collector #(
    .NUM_CHILD(NC),
    .DATA_W(DW),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .child_valid(child_valid),
    .child_data(child_data),
    .child_ready(child_ready),
    .up_valid(up_valid),
    .up_ready(up_ready),
    .up_data(up_data),
    .up_src(up_src),
    .fifo_level(fifo_level)
`ifdef COLLECTOR_STATS_EN
    ,
    .beat_count(beat_count),
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: each entry holds src*65536 + data.
  int mq[$];
  int m_last;
  int m_beats;
  int m_stalls;
  int m_g;
  bit m_push;
  bit m_pop;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_grant();
    for (int k = 1; k <= NC; k++) begin
      int idx;
      idx = (m_last + k) % NC;
      if (child_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NC-1:0] exp_ready();
    int g;
    g = exp_grant();
    if (g < 0 || mq.size() >= FD) return '0;
    return NC'(1) << g;
  endfunction

  // Model update on each rising edge from the inputs held across it.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_last   = NC - 1;
      m_beats  = 0;
      m_stalls = 0;
      chk_en   = 1'b1;
    end else begin
      m_g    = exp_grant();
      m_push = (m_g >= 0) && (mq.size() < FD);
      m_pop  = (mq.size() != 0) && up_ready;
      if (mq.size() != 0 && !up_ready && m_stalls < 65535) m_stalls++;
      if (m_pop) begin
        void'(mq.pop_front());
        m_beats++;
      end
      if (m_push) begin
        mq.push_back(m_g * 65536 + int'(child_data[m_g*DW +: DW]));
        m_last = m_g;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("model_child_ready", child_ready, exp_ready());
      checkOutput("model_up_valid", up_valid, mq.size() != 0);
      checkOutput("model_fifo_level", fifo_level, mq.size());
      if (mq.size() != 0) begin
        checkOutput("model_up_data", up_data, mq[0] % 65536);
        checkOutput("model_up_src", up_src, mq[0] / 65536);
      end
`ifdef COLLECTOR_STATS_EN
      checkOutput("model_beat_count", beat_count, m_beats);
      checkOutput("model_stall_cycles", stall_cycles, m_stalls);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NC-1:0] v, input logic r);
    child_valid = v;
    up_ready    = r;
  endtask

  task automatic setData(input int ch, input logic [DW-1:0] d);
    child_data[ch*DW +: DW] = d;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [NC-1:0] rr_ready_tab [10] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000,
                                       5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
  int            rr_src_tab   [9]  = '{0, 1, 2, 3, 4, 0, 1, 2, 3};
  logic [NC-1:0] bp_ready_tab [4]  = '{5'b00010, 5'b01000, 5'b00010, 5'b01000};
  int            bp_drain_tab [3]  = '{1, 3, 1};

  initial begin
    // Reset state
    applyStimulus('0, 1'b0);
    tick();
    tick();
    settle();
    checkOutput("rst_up_valid", up_valid, 0);
    checkOutput("rst_fifo_level", fifo_level, 0);
    checkOutput("rst_child_ready", child_ready, 0);
    checkOutput("rst_up_data", up_data, 0);
    checkOutput("rst_up_src", up_src, 0);
    tick();
    rst = 1'b0;

    // Single beat from child 2
    setData(2, 16'hA5A5);
    applyStimulus(5'b00100, 1'b1);
    settle();
    checkOutput("sb_child_ready", child_ready, 5'b00100);
    tick();
    applyStimulus('0, 1'b1);
    settle();
    checkOutput("sb_up_valid", up_valid, 1);
    checkOutput("sb_up_data", up_data, 16'hA5A5);
    checkOutput("sb_up_src", up_src, 2);
    checkOutput("sb_fifo_level", fifo_level, 1);
    tick();
    settle();
    checkOutput("sb_empty_valid", up_valid, 0);
    checkOutput("sb_empty_level", fifo_level, 0);
    tick();

    // Round-robin fairness with every child valid
    pulseReset();
    for (int i = 0; i < NC; i++) setData(i, 16'hB000 + 16'(i));
    for (int c = 0; c < 10; c++) begin
      applyStimulus(5'b11111, 1'b1);
      settle();
      checkOutput("rr_child_ready", child_ready, rr_ready_tab[c]);
      if (c >= 1) begin
        checkOutput("rr_up_src", up_src, rr_src_tab[c-1]);
        checkOutput("rr_fifo_level", fifo_level, 1);
      end
      tick();
    end
    applyStimulus('0, 1'b1);
    settle();
    tick();

    // Backpressure until full, then a pop at full, then drain
    pulseReset();
    setData(1, 16'h1111);
    setData(3, 16'h3333);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(5'b01010, 1'b0);
      settle();
      checkOutput("bp_child_ready", child_ready, bp_ready_tab[c]);
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      applyStimulus(5'b01010, 1'b0);
      settle();
      checkOutput("bp_full_level", fifo_level, 4);
      checkOutput("bp_full_ready", child_ready, 0);
      checkOutput("bp_head_src", up_src, 1);
      checkOutput("bp_head_data", up_data, 16'h1111);
      tick();
    end
    applyStimulus(5'b01010, 1'b1);
    settle();
    checkOutput("full_pop_ready", child_ready, 0);
    checkOutput("full_pop_level", fifo_level, 4);
    tick();
    applyStimulus(5'b01010, 1'b1);
    settle();
    checkOutput("after_pop_ready", child_ready, 5'b00010);
    checkOutput("after_pop_level", fifo_level, 3);
    tick();
    applyStimulus('0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      settle();
      checkOutput("bp_drain_src", up_src, bp_drain_tab[c]);
      tick();
    end
    settle();
    checkOutput("bp_drained_level", fifo_level, 0);
    tick();

    // Simultaneous push and pop at level 2
    pulseReset();
    for (int c = 0; c < 2; c++) begin
      setData(0, 16'hC000 + 16'(c));
      applyStimulus(5'b00001, 1'b0);
      settle();
      tick();
    end
    for (int c = 2; c < 5; c++) begin
      setData(0, 16'hC000 + 16'(c));
      applyStimulus(5'b00001, 1'b1);
      settle();
      checkOutput("pp_level", fifo_level, 2);
      checkOutput("pp_head_data", up_data, 16'hC000 + 16'(c - 2));
      tick();
    end
    applyStimulus('0, 1'b1);
    settle();
    tick();
    settle();
    tick();
    settle();
    checkOutput("pp_drained_level", fifo_level, 0);
    tick();

    // Reset in the middle of a burst
    pulseReset();
    setData(0, 16'hD000);
    setData(2, 16'hD002);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(5'b00001, 1'b0);
      settle();
      tick();
    end
    settle();
    checkOutput("mr_level_before", fifo_level, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(5'b00101, 1'b0);
    settle();
    checkOutput("mr_up_valid", up_valid, 0);
    checkOutput("mr_level", fifo_level, 0);
    checkOutput("mr_grant", child_ready, 5'b00001);
    tick();
    applyStimulus('0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      settle();
      tick();
    end

`ifdef COLLECTOR_STATS_EN
    // Statistics: 3 stalled cycles and 7 pops
    pulseReset();
    setData(0, 16'hE000);
    applyStimulus(5'b00001, 1'b0);
    settle();
    tick();
    for (int c = 0; c < 3; c++) begin
      applyStimulus('0, 1'b0);
      settle();
      tick();
    end
    for (int c = 0; c < 6; c++) begin
      applyStimulus(5'b00001, 1'b1);
      settle();
      tick();
    end
    applyStimulus('0, 1'b1);
    settle();
    tick();
    settle();
    checkOutput("st_beat_count", beat_count, 7);
    checkOutput("st_stall_cycles", stall_cycles, 3);
    pulseReset();
    settle();
    checkOutput("st_beat_count_rst", beat_count, 0);
    checkOutput("st_stall_cycles_rst", stall_cycles, 0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
